// File: rtl/storage_access_arbiter.sv
// storage_access_arbiter: round-robin, burst-holding owner of the single-port storage RAM
// with bounded hold time and per-master read-valid return.
module storage_access_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              in_gnt,
  input  logic              calc_req,
  input  logic              calc_we,
  input  logic [ADDR_W-1:0] calc_addr,
  input  logic [DATA_W-1:0] calc_wdata,
  output logic              calc_gnt,
  output logic              calc_rvalid,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN_IN = 2'b01, OWN_CALC = 2'b10, OWN_DISP = 2'b11} state_t;
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);
  state_t state, state_next, last;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0] req, others;
  logic active, yield;
  function automatic state_t nxt(input state_t s);
    return s == OWN_DISP ? OWN_IN : state_t'(s + 2'd1);
  endfunction
  // First requester strictly after 'after' in IN -> CALC -> DISP order, or IDLE.
  function automatic state_t rr(input logic [3:0] r, input state_t after);
    state_t c1, c2, c3;
    c1 = nxt(after);
    c2 = nxt(c1);
    c3 = nxt(c2);
    return r[c1] ? c1 : r[c2] ? c2 : r[c3] ? c3 : IDLE;
  endfunction
  always_comb begin
    req = {disp_req, calc_req, in_req, 1'b0};
    others = req & ~(4'b1 << state);
    active = req[state];
    yield = !active || (cnt == CMAX && |others);
    state_next = state == IDLE ? rr(req, last) : yield ? rr(others, state) : state;
    mem_we = active && (state == OWN_IN || (state == OWN_CALC && calc_we));
    mem_addr = !active ? addr_q : state == OWN_IN ? in_addr : state == OWN_CALC ? calc_addr : disp_addr;
    mem_wdata = active && state == OWN_IN ? in_wdata : active && state == OWN_CALC ? calc_wdata : wdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= OWN_DISP;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      calc_rvalid <= 1'b0;
      disp_rvalid <= 1'b0;
    end else begin
      state <= state_next;
      last <= state != IDLE ? state : last;
      cnt <= state_next != state ? '0 : cnt == CMAX ? cnt : cnt + 1'b1;
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
      calc_rvalid <= calc_gnt && calc_req && !calc_we;
      disp_rvalid <= disp_gnt && disp_req;
    end
  end
  assign in_gnt = state == OWN_IN;
  assign calc_gnt = state == OWN_CALC;
  assign disp_gnt = state == OWN_DISP;
  assign owner = state;
  assign rdata = mem_rdata;
endmodule

// File: tb/tb_storage_access_arbiter.sv
// tb_storage_access_arbiter: directed tests with a read-return scoreboard over a
// 1-cycle-latency RAM model.
module tb_storage_access_arbiter;
  logic clk = 0, rst = 1;
  logic in_req = 0, calc_req = 0, calc_we = 0, disp_req = 0;
  logic [8:0] in_addr = 0, calc_addr = 0, disp_addr = 0, mem_addr;
  logic [31:0] in_wdata = 0, calc_wdata = 0, rdata, mem_wdata, mem_rdata;
  logic in_gnt, calc_gnt, calc_rvalid, disp_gnt, disp_rvalid, mem_we;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  typedef struct packed {logic disp; logic [31:0] data;} rd_t;
  rd_t sb[$];
  rd_t mon_e;
  bit [31:0] ram [512];
  bit written [512];

  storage_access_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .in_req(in_req), .in_addr(in_addr), .in_wdata(in_wdata), .in_gnt(in_gnt),
    .calc_req(calc_req), .calc_we(calc_we), .calc_addr(calc_addr), .calc_wdata(calc_wdata),
    .calc_gnt(calc_gnt), .calc_rvalid(calc_rvalid),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [8:0] a);
    return a == 9'h010 ? 32'hDEADBEEF : a == 9'h100 ? 32'hCAFEF00D : a == 9'h005 ? 32'h55AA1234 : 32'h0;
  endfunction

  function automatic logic [31:0] ram_word(input logic [8:0] a);
    return written[a] ? ram[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_word(mem_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (calc_rvalid || disp_rvalid)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=calc%0b/disp%0b expected=no read return", calc_rvalid, disp_rvalid);
      end else begin
        mon_e = sb.pop_front();
        check("sb_src", {62'd0, disp_rvalid, calc_rvalid}, mon_e.disp ? 64'd2 : 64'd1);
        check("sb_rdata", {32'd0, rdata}, {32'd0, mon_e.data});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    // 1: reset then quiet bus
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", {57'd0, in_gnt, calc_gnt, disp_gnt, mem_we, owner}, 64'd0);
    end
    // 2: single calc read
    calc_req = 1; calc_we = 0; calc_addr = 9'h010;
    sb.push_back(rd_t'{disp: 1'b0, data: 32'hDEADBEEF});
    tick();
    check("t2_gnt", {61'd0, in_gnt, calc_gnt, disp_gnt}, 64'b010);
    check("t2_addr", {54'd0, mem_we, mem_addr}, {54'd0, 1'b0, 9'h010});
    tick();
    check("t2_rvalid", {31'd0, calc_rvalid, rdata}, {31'd0, 1'b1, 32'hDEADBEEF});
    calc_req = 0;
    repeat (3) tick();
    // 3: three-way rotation with hold expiry
    reset_dut();
    in_req = 1; in_addr = 9'h031; in_wdata = 32'h11111111;
    calc_req = 1; calc_we = 1; calc_addr = 9'h032; calc_wdata = 32'h22222222;
    disp_req = 1; disp_addr = 9'h100;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("t3_gnt_%0d", k), {61'd0, in_gnt, calc_gnt, disp_gnt},
            k <= 4 ? 64'b100 : k <= 8 ? 64'b010 : k <= 12 ? 64'b001 : 64'b100);
      if (k == 1) check("t3_in_wr", {54'd0, mem_we, mem_addr}, {54'd0, 1'b1, 9'h031});
      if (k == 5) check("t3_calc_wr", {54'd0, mem_we, mem_addr}, {54'd0, 1'b1, 9'h032});
      if (k == 9) check("t3_disp_rd", {54'd0, mem_we, mem_addr}, {54'd0, 1'b0, 9'h100});
      if (k >= 9 && k <= 12) sb.push_back(rd_t'{disp: 1'b1, data: 32'hCAFEF00D});
    end
    in_req = 0; calc_req = 0; disp_req = 0;
    repeat (3) tick();
    // 4: lone display keeps the bus past the hold limit
    reset_dut();
    disp_req = 1; disp_addr = 9'h100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t4_gnt_%0d", k), {62'd0, disp_gnt, owner == 2'b11}, 64'b11);
      if (k < 20) sb.push_back(rd_t'{disp: 1'b1, data: 32'hCAFEF00D});
    end
    disp_req = 0;
    repeat (3) tick();
    // 5: reset in the middle of an input burst
    reset_dut();
    in_req = 1; in_addr = 9'h020; in_wdata = 32'd1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      in_addr = 9'h020 + 9'(k - 1);
      in_wdata = 32'(k);
      if (k == 5) begin
        #1 check("t5_we_before", {63'd0, mem_we}, 64'd1);
        rst = 1;
        #1 check("t5_async", {59'd0, mem_we, in_gnt, calc_gnt, disp_gnt, owner}, 64'd0);
      end
    end
    in_req = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++)
      check($sformatf("t5_ram_%0h", 9'h020 + 9'(i)), {32'd0, ram_word(9'h020 + 9'(i))},
            i < 4 ? 64'(i + 1) : 64'd0);
    // 6: in-flight calc read delivered across a handoff to display
    calc_req = 1; calc_we = 1; calc_addr = 9'h040; calc_wdata = 32'h12345678;
    tick();
    check("t6_calc_gnt", {63'd0, calc_gnt}, 64'd1);
    disp_req = 1; disp_addr = 9'h100;
    tick();
    tick();
    tick();
    check("t6_calc_hold", {62'd0, calc_gnt, disp_gnt}, 64'b10);
    calc_we = 0; calc_addr = 9'h005;
    sb.push_back(rd_t'{disp: 1'b0, data: 32'h55AA1234});
    tick();
    check("t6_handoff", {62'd0, calc_gnt, disp_gnt}, 64'b01);
    check("t6_rvalid", {30'd0, calc_rvalid, disp_rvalid, rdata}, {30'd0, 2'b10, 32'h55AA1234});
    calc_req = 0; disp_req = 0;
    repeat (3) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
